// File: rtl/aurora_pkg.sv
// Shared definitions for the execute-stage M-extension unit:
// operand width, func3/func7 decode constants and the FSM state encoding.
package aurora_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit in the execute stage.
// Operates on operand magnitudes: shift-add for multiply, restoring
// shift-subtract for divide (one bit per clock), then applies the sign fix
// on the final iteration. Stalls the front of the pipeline while working
// and emits a one-cycle registered done pulse with the result.
// Build option: MULDIV_EARLY_OUT_EN lets divide-by-zero and signed overflow
// finish straight from IDLE (latency 1); otherwise they take the full
// XLEN iterations and produce the same result.
module ex_muldiv_unit
  import aurora_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            start_in,
  input  logic [2:0]      func3_in,
  input  logic [XLEN-1:0] R1out_in,
  input  logic [XLEN-1:0] R2out_in,
  input  logic [4:0]      WReg1_in,
  output logic            stall_out,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      WReg1_out,
  output logic            WRegEn_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  // Absolute value when the operand is interpreted as signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
    mag = (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

  // One shift-add step: acc = {partial_hi, multiplier_lo}.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_step = {sum, acc[XLEN-1:1]};
  endfunction

  // One restoring step: acc = {remainder, dividend/quotient}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   dvs);
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    rem_sh = acc[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[XLEN]) div_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else             div_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  endfunction

  // Sign fix and result selection once all iterations are done.
  // Divide by zero only needs the quotient forced: the restoring loop already
  // leaves the dividend magnitude as remainder, and signed overflow falls out
  // of the magnitude arithmetic naturally.
  function automatic logic [XLEN-1:0] finish(input logic [2:0]        op,
                                             input logic [2*XLEN-1:0] acc,
                                             input logic              neg,
                                             input logic              rneg,
                                             input logic              divz);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg  ? -acc : acc;
    quo  = neg  ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:                       finish = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: finish = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              finish = divz ? '1 : quo;
      default:                      finish = rem;
    endcase
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  // Architecturally defined results for the cases that bypass iteration.
  function automatic logic [XLEN-1:0] early_result(input logic [2:0]      op,
                                                   input logic [XLEN-1:0] r1,
                                                   input logic            divz);
    case (op)
      F3_DIV:  early_result = divz ? '1 : SMIN;
      F3_DIVU: early_result = '1;
      F3_REM:  early_result = divz ? r1 : '0;
      default: early_result = r1;
    endcase
  endfunction
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [4:0]            wreg_q, wreg_d;
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic                  rneg_q, rneg_d;
  logic                  divz_q, divz_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  done_q, done_d;

  logic                  rs1_signed, rs2_signed;
  logic                  rs1_neg, rs2_neg;
  logic [XLEN-1:0]       rs1_mag, rs2_mag;
  logic                  div_op_in, div_zero_in;
  logic [2*XLEN-1:0]     step;

  assign rs1_signed  = (func3_in == F3_MULH) || (func3_in == F3_MULHSU) ||
                       (func3_in == F3_DIV)  || (func3_in == F3_REM);
  assign rs2_signed  = (func3_in == F3_MULH) || (func3_in == F3_DIV) || (func3_in == F3_REM);
  assign rs1_neg     = rs1_signed & R1out_in[XLEN-1];
  assign rs2_neg     = rs2_signed & R2out_in[XLEN-1];
  assign rs1_mag     = mag(R1out_in, rs1_signed);
  assign rs2_mag     = mag(R2out_in, rs2_signed);
  assign div_op_in   = func3_in[2];
  assign div_zero_in = div_op_in && (R2out_in == '0);
  assign step        = op_q[2] ? div_step(acc_q, dvs_q) : mul_step(acc_q, dvs_q);

`ifdef MULDIV_EARLY_OUT_EN
  logic div_ovf_in;
  assign div_ovf_in = ((func3_in == F3_DIV) || (func3_in == F3_REM)) &&
                      (R1out_in == SMIN) && (R2out_in == '1);
`endif

  // Next-state: capture in IDLE, iterate in BUSY, single-cycle DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    wreg_d   = wreg_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    divz_d   = divz_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          op_d    = func3_in;
          wreg_d  = WReg1_in;
          neg_d   = rs1_neg ^ rs2_neg;
          rneg_d  = rs1_neg;
          divz_d  = div_zero_in;
          cnt_d   = '0;
          dvs_d   = div_op_in ? rs2_mag : rs1_mag;
          acc_d   = {{XLEN{1'b0}}, (div_op_in ? rs1_mag : rs2_mag)};
          state_d = ST_BUSY;
`ifdef MULDIV_EARLY_OUT_EN
          if (div_zero_in || div_ovf_in) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = early_result(func3_in, R1out_in, div_zero_in);
          end
`endif
        end
      end
      ST_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IT) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = finish(op_q, step, neg_q, rneg_q, divz_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      wreg_q   <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      wreg_q   <= wreg_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      divz_q   <= divz_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign stall_out  = start_in && !done_q;
  assign busy_out   = (state_q == ST_BUSY);
  assign done_out   = done_q;
  assign WRegEn_out = done_q;
  assign result_out = result_q;
  assign WReg1_out  = wreg_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: the driver pushes the model result
// for each issued instruction; a monitor pops and compares on every done.
module tb_ex_muldiv_unit;
  import aurora_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_in;
  logic [2:0]  func3_in;
  logic [63:0] R1out_in;
  logic [63:0] R2out_in;
  logic [4:0]  WReg1_in;
  logic        stall_out;
  logic        busy_out;
  logic        done_out;
  logic [63:0] result_out;
  logic [4:0]  WReg1_out;
  logic        WRegEn_out;

  ex_muldiv_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_in   (start_in),
    .func3_in   (func3_in),
    .R1out_in   (R1out_in),
    .R2out_in   (R2out_in),
    .WReg1_in   (WReg1_in),
    .stall_out  (stall_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .result_out (result_out),
    .WReg1_out  (WReg1_out),
    .WRegEn_out (WRegEn_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  wr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [63:0] SMIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: RISC-V M-extension semantics using wide plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] p;
    longint       sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    ref_model = '0;
    case (f3)
      F3_MUL:    begin p = {64'b0, a} * {64'b0, b}; ref_model = p[63:0]; end
      F3_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; ref_model = p[127:64]; end
      F3_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b}; ref_model = p[127:64]; end
      F3_MULHU:  begin p = {64'b0, a} * {64'b0, b}; ref_model = p[127:64]; end
      F3_DIV: begin
        if (b == 64'd0) ref_model = ONES64;
        else if (a == SMIN64 && b == ONES64) ref_model = SMIN64;
        else ref_model = 64'(sa / sb);
      end
      F3_DIVU: ref_model = (b == 64'd0) ? ONES64 : a / b;
      F3_REM: begin
        if (b == 64'd0) ref_model = a;
        else if (a == SMIN64 && b == ONES64) ref_model = 64'd0;
        else ref_model = 64'(sa % sb);
      end
      default: ref_model = (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    is_special = f3[2] && ((b == 64'd0) ||
                 ((f3 == F3_DIV || f3 == F3_REM) && a == SMIN64 && b == ONES64));
  endfunction

  // Issue one instruction from a negedge in IDLE; hold start through DONE and
  // return at the negedge of the following IDLE cycle with start still high.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] wr);
    int lat;
    int exp_lat;
    bit stall_ok;
    bit got;
    func3_in = f3;
    R1out_in = a;
    R2out_in = b;
    WReg1_in = wr;
    start_in = 1'b1;
    sb_q.push_back('{res: ref_model(f3, a, b), wr: wr});
    exp_lat  = (EARLY && is_special(f3, a, b)) ? 1 : 65;
    lat      = 0;
    stall_ok = 1'b1;
    got      = 1'b0;
    while (!got && lat <= 200) begin
      #1;
      if (done_out) got = 1'b1;
      else begin
        if (!stall_out) stall_ok = 1'b0;
        if (lat == 1) chk("busy_during_op", 64'(busy_out), 64'd1);
        @(negedge CLK);
        lat++;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL done_timeout: no done after %0d cycles, required within %0d", lat, exp_lat);
    end else begin
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("stall_low_on_done", 64'(stall_out), 64'd0);
      chk("stall_high_while_waiting", 64'(stall_ok), 64'd1);
      @(negedge CLK);
      chk("idle_after_done", {62'd0, busy_out, done_out}, 64'd0);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (done_out) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: result_out=%h with nothing outstanding, required no pulse", result_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", result_out, mon_e.res);
        chk("wreg_out", 64'(WReg1_out), 64'(mon_e.wr));
        chk("wregen", 64'(WRegEn_out), 64'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [63:0] a, b;
    int          sel;
    RST      = 1'b1;
    start_in = 1'b0;
    func3_in = '0;
    R1out_in = '0;
    R2out_in = '0;
    WReg1_in = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_result", result_out, 64'd0);
    chk("rst_wreg", 64'(WReg1_out), 64'd0);
    chk("rst_wregen", 64'(WRegEn_out), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Directed cases, back-to-back with start held through each DONE.
    issue(F3_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd5);
    issue(F3_MULHU,  ONES64, ONES64, 5'd6);
    issue(F3_MULH,   ONES64, ONES64, 5'd7);
    issue(F3_DIV,    -64'sd7, 64'd2, 5'd8);
    issue(F3_REM,    -64'sd7, 64'd2, 5'd9);
    issue(F3_DIVU,   64'd100, 64'd7, 5'd10);
    issue(F3_DIVU,   64'd5, 64'd0, 5'd11);
    issue(F3_REMU,   64'd5, 64'd0, 5'd12);
    issue(F3_DIV,    SMIN64, ONES64, 5'd13);
    issue(F3_REM,    SMIN64, ONES64, 5'd14);
    issue(F3_DIV,    -64'sd9, 64'd0, 5'd15);
    issue(F3_MULHSU, -64'sd1, ONES64, 5'd16);
    start_in = 1'b0;
    @(negedge CLK);

    // Reset in the middle of an operation: abandoned, no done pulse.
    func3_in = F3_MUL;
    R1out_in = 64'h1234_5678_9ABC_DEF0;
    R2out_in = 64'd77;
    WReg1_in = 5'd20;
    start_in = 1'b1;
    repeat (21) @(negedge CLK);
    RST      = 1'b1;
    start_in = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("midrst_busy", 64'(busy_out), 64'd0);
    chk("midrst_done", 64'(done_out), 64'd0);
    chk("midrst_result", result_out, 64'd0);
    chk("midrst_wreg", 64'(WReg1_out), 64'd0);
    repeat (80) @(negedge CLK);
    chk("midrst_still_idle", 64'(busy_out), 64'd0);
    issue(F3_MUL, 64'd6, 64'd7, 5'd9);
    start_in = 1'b0;
    @(negedge CLK);

    // Randomized instructions, sometimes back-to-back, sometimes with gaps.
    for (int i = 0; i < 30; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 64'd0;
      else if (sel == 1) begin a = SMIN64; b = ONES64; end
      else if (sel == 2) b = 64'($urandom_range(1, 1000));
      else if (sel == 3) a = 64'($urandom_range(0, 1000));
      issue(f3, a, b, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1) begin
        start_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
    end
    start_in = 1'b0;
    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register outputs. Performs RV64M multiply/divide iteratively on operands registered by ID/EX.
- Holds the upstream pipeline with a stall while busy. Presents one registered result with a one-cycle done pulse for the EX/MEM register.
- Sits beside the single-cycle ALU; the ALU result mux selects result_out when done_out is high.

Parameters:
- XLEN, 64, operand/result width; iteration count per operation.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- start_in  input  1  valid M-extension instruction in EX (decoded func7==7'b0000001, R-type); held stable while stall_out is high.
- func3_in  input  3  operation select (encoding below).
- R1out_in  input  XLEN  rs1 operand.
- R2out_in  input  XLEN  rs2 operand.
- WReg1_in  input  5  destination register.
- stall_out  output  1  combinational: start_in && !done_out; freezes PC, IF/ID and ID/EX.
- busy_out  output  1  high while state is BUSY.
- done_out  output  1  registered one-cycle pulse; result valid.
- result_out  output  XLEN  registered result; holds its value until the next done.
- WReg1_out  output  5  destination captured at start; valid with done_out.
- WRegEn_out  output  1  equals done_out; write enable for EX/MEM when WReg1_out != 0.

Behaviour:
- Reset: one clock, synchronous and active-high, as already decided.
  - RST=1 at an edge: state=IDLE, iteration counter=0, busy_out=0, done_out=0, result_out=0, WReg1_out=0, WRegEn_out=0.
  - Internal accumulators and operand registers are also cleared.
- func3 encoding:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: signed×signed, high half.
  - 010 MULHSU: signed×unsigned, high half.
  - 011 MULHU: unsigned×unsigned, high half.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States:
  - IDLE: start_in=1 at an edge captures func3, WReg1 and operand magnitudes (absolute value for signed operands), records the result sign, sets counter=0 and goes to BUSY.
  - BUSY: each edge performs one iteration.
    - Multiply: shift-add into a 2*XLEN product.
    - Divide: restoring shift-subtract, producing one quotient bit per edge.
    - counter increments each edge. After iteration XLEN-1 the state goes to DONE, and result_out, done_out and WRegEn_out are registered in the same edge.
  - DONE (one cycle, done_out=1): always returns to IDLE. start_in is ignored here, so the instruction being released is never re-accepted.
- Latency: start sampled at edge k gives done_out high in the cycle after edge k+XLEN (XLEN+1 cycles; 65 for XLEN=64).
- Sign fix at completion:
  - Product negated when the operand signs differ (signed variants only).
  - Quotient negated when the signs differ; remainder takes the sign of the dividend.
- Special cases (RISC-V defined; no exceptions raised):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = dividend.
  - Signed overflow (DIV of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1); REM result = 0.
- start_in while BUSY: no effect; operands are already captured.
- RST during BUSY: the operation is abandoned, no done pulse, IDLE next cycle.
- stall_out is high in IDLE and BUSY while start_in=1, and low in the DONE cycle so the pipeline advances exactly once.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases skip BUSY. IDLE goes directly to DONE, giving latency 1 (done_out in the cycle after the start edge).
- Undefined: these cases run the full XLEN iterations and the special result is forced at completion. Latency is a uniform XLEN+1.
- Results are identical in both builds.

Decomposition:
- Shared package aurora_pkg:
  - XLEN.
  - func3 localparams (F3_MUL..F3_REMU) and the M-extension func7 constant 7'b0000001.
  - 2-bit state encoding (IDLE=0, BUSY=1, DONE=2).
- No sub-module needed: one module with a counter, a shared 2*XLEN shift register, and sign-fix logic.

Test Plan:
- MUL: R1=3, R2=-4 (0xFFFF_FFFF_FFFF_FFFC), start at cycle 0.
  - stall_out high cycles 0-64; done_out only at cycle 65, result 0xFFFF_FFFF_FFFF_FFF4, WReg1_out=WReg1_in.
- MULHU: all-ones × all-ones -> result 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1). DIVU 100/7 -> 14.
- DIVU 5/0 -> all ones. REMU 5/0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000. REM for the same operands -> 0.
  - Latency 1 with MULDIV_EARLY_OUT_EN defined, 65 without.
- RST=1 at BUSY iteration 20 -> busy_out=0 next cycle, no done_out pulse. A following MUL 6×7 -> 42 with full latency.
- Back-to-back: start held through DONE -> exactly one done pulse per instruction. A second start presented in the cycle after DONE is accepted from IDLE.
